// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed, checksummed byte stream and writes little-endian
// 32-bit words into instruction memory, holding the core in reset until verified.
module imem_boot_loader #(
    parameter int          ADDR_W    = 9,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [15:0] MAX_N = 16'(1 << ADDR_W);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              xfer;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   cnt_inc;

    assign in_ready  = (state_q != S_DONE);
    assign core_rst  = (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign xfer     = in_valid && in_ready;
    assign len_full = {in_data, len_lo_q};
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        bidx_d   = bidx_q;
        asm_d    = asm_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (xfer) begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (in_data == SYNC_BYTE) state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_lo_d = in_data;
                    state_d  = S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (len_full > MAX_N) begin
                        state_d = S_ERROR;
                    end else begin
                        n_d     = len_full[ADDR_W:0];
                        cnt_d   = '0;
                        bidx_d  = '0;
                        csum_d  = '0;
                        state_d = (len_full == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: begin
                    csum_d = csum_q ^ in_data;
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: begin
                            // 4th byte completes the word; write is issued without stalling the stream
                            we_d    = 1'b1;
                            addr_d  = cnt_q[ADDR_W-1:0];
                            wdata_d = {in_data, asm_q};
                            cnt_d   = cnt_inc;
                            if (cnt_inc == n_q) state_d = S_CSUM;
                        end
                    endcase
                end
                S_CSUM: begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            bidx_q   <= '0;
            asm_q    <= '0;
            csum_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            asm_q    <= asm_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frame-position reference model checked every cycle,
// directed frames with literal expectations, then randomized frames.
module tb_imem_boot_loader;

    localparam int ADDR_W = 9;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    imem_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: tracks byte position within the current frame.
    bit          mdone = 0, merr = 0, inframe = 0;
    int          pos = 0, nw = 0;
    logic [7:0]  lo = '0, mx = '0;
    logic [7:0]  wb [4];
    logic        exp_we = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mdone = 0; merr = 0; inframe = 0; pos = 0;
                exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
            end else begin
                exp_we = 1'b0;
                if (in_valid && !mdone) begin
                    if (!inframe) begin
                        if (in_data == 8'hA5) begin inframe = 1; merr = 0; pos = 1; end
                    end else if (pos == 1) begin
                        lo = in_data; pos = 2;
                    end else if (pos == 2) begin
                        nw = int'({in_data, lo});
                        if (nw > CAP) begin merr = 1; inframe = 0; end
                        else begin mx = '0; pos = 3; end
                    end else if (pos < 3 + 4 * nw) begin
                        wb[(pos - 3) % 4] = in_data;
                        mx = mx ^ in_data;
                        if ((pos - 3) % 4 == 3) begin
                            exp_we    = 1'b1;
                            exp_addr  = ADDR_W'((pos - 3) / 4);
                            exp_wdata = {wb[3], wb[2], wb[1], wb[0]};
                        end
                        pos++;
                    end else begin
                        if (in_data == mx) mdone = 1; else merr = 1;
                        inframe = 0;
                    end
                end
            end
        end
    end

    int compared = 0;
    int mismatched = 0;
    int wcount = 0;
    int last_addr = -1;
    logic [31:0] shadow [CAP];
    logic [7:0]  fq [$];
    logic [31:0] wq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, {31'd0, !mdone});
        check("core_rst", {31'd0, core_rst}, {31'd0, !mdone});
        check("done", {31'd0, done}, {31'd0, mdone});
        check("error", {31'd0, error}, {31'd0, merr});
        check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        check("mem_addr", {23'd0, mem_addr}, {23'd0, exp_addr});
        check("mem_wdata", mem_wdata, exp_wdata);
        if (mem_we) begin
            shadow[mem_addr] = mem_wdata;
            wcount++;
            last_addr = int'(mem_addr);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit throttle);
        if (throttle) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_q(input bit throttle);
        foreach (fq[i]) send_byte(fq[i], throttle);
        tick();
    endtask

    task automatic build_frame(input bit bad);
        logic [7:0] x;
        logic [15:0] n;
        x = '0;
        n = 16'(wq.size());
        fq.delete();
        fq.push_back(8'hA5);
        fq.push_back(n[7:0]);
        fq.push_back(n[15:8]);
        foreach (wq[i]) begin
            for (int unsigned k = 0; k < 4; k++) begin
                fq.push_back(wq[i][8*k +: 8]);
                x = x ^ wq[i][8*k +: 8];
            end
        end
        fq.push_back(bad ? ~x : x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        wcount = 0;
        last_addr = -1;
        for (int i = 0; i < CAP; i++) shadow[i] = '0;
    endtask

    initial begin
        do_reset();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);

        // Two-word load; XOR of the eight data bytes is 0x2A
        fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_q(0);
        check("two_w0", shadow[0], 32'h12345678);
        check("two_w1", shadow[1], 32'hDEADBEEF);
        check("two_wcount", wcount, 32'd2);
        check("two_done", {31'd0, done}, 32'd1);
        check("two_core_rst", {31'd0, core_rst}, 32'd0);
        check("two_in_ready", {31'd0, in_ready}, 32'd0);

        do_reset();
        fq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_q(0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_wcount", wcount, 32'd0);

        do_reset();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        send_q(0);
        check("bad_error", {31'd0, error}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_core_rst", {31'd0, core_rst}, 32'd1);
        check("bad_wcount", wcount, 32'd2);
        fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_q(0);
        check("retry_error", {31'd0, error}, 32'd0);
        check("retry_done", {31'd0, done}, 32'd1);

        do_reset();
        fq = '{8'hA5, 8'h01, 8'h02};
        send_q(0);
        check("ovf_error", {31'd0, error}, 32'd1);
        check("ovf_wcount", wcount, 32'd0);
        wq.delete();
        for (int i = 0; i < CAP; i++) wq.push_back($urandom);
        build_frame(0);
        send_q(1);
        check("max_done", {31'd0, done}, 32'd1);
        check("max_wcount", wcount, 32'd512);
        check("max_last_addr", last_addr, 32'd511);
        check("max_last_word", shadow[511], wq[511]);

        do_reset();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_q(1);
        check("thr_w0", shadow[0], 32'h12345678);
        check("thr_w1", shadow[1], 32'hDEADBEEF);
        check("thr_wcount", wcount, 32'd2);
        check("thr_done", {31'd0, done}, 32'd1);

        // Reset asserted mid-DATA, between clock edges
        do_reset();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
        foreach (fq[i]) send_byte(fq[i], 0);
        #2 rst = 1'b0;
        #1;
        check("mid_mem_we", {31'd0, mem_we}, 32'd0);
        check("mid_mem_addr", {23'd0, mem_addr}, 32'd0);
        check("mid_mem_wdata", mem_wdata, 32'd0);
        check("mid_core_rst", {31'd0, core_rst}, 32'd1);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_error", {31'd0, error}, 32'd0);
        check("mid_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst = 1'b1;
        wcount = 0;
        wq = '{32'hCAFEF00D, 32'h0BADBEEF};
        build_frame(0);
        send_q(0);
        check("mid_reload_w0", shadow[0], 32'hCAFEF00D);
        check("mid_reload_wcount", wcount, 32'd2);
        check("mid_reload_done", {31'd0, done}, 32'd1);

        for (int it = 0; it < 30; it++) begin
            do_reset();
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h5A;
                send_byte(gb, 1);
            end
            wq.delete();
            for (int w = $urandom_range(0, 6); w > 0; w--) wq.push_back($urandom);
            build_frame($urandom_range(0, 3) == 0);
            send_q($urandom_range(0, 1) == 1);
            if (merr) begin
                build_frame(0);
                send_q(1);
            end
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
